dual_fifo_wr_arb: RTL and testbench
===================================

Name: dual_fifo_wr_arb

Overview:
- Two-requester arbiter for the single dual-issue write port of a dual_fifo instance.
- Each cycle one requester is granted. Its 0/1/2-entry valid, data and backpressure pass straight through to the FIFO write side.
- Round-robin fairness, with an optional per-requester lock that keeps ownership across multi-cycle bursts.
- Placed between producers (e.g. fetch and replay paths) and the instruction FIFO.

Parameters:
- Width, 32, data width of each entry lane.
- CntW, 16, width of the per-requester transfer counters (only used when the optional feature is enabled).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of arbiter state
- req0_valid_i  in  2  requester 0 valid (00/01/11 legal)
- req0_data0_i  in  Width  requester 0, first sequential entry
- req0_data1_i  in  Width  requester 0, second sequential entry
- req0_lock_i  in  1  requester 0 requests burst ownership
- req0_rdy_o  out  2  requester 0 ready (00/01/11)
- req1_valid_i, req1_data0_i, req1_data1_i, req1_lock_i, req1_rdy_o  same as requester 0
- fifo_wr_valid_o  out  2  to FIFO write valid
- fifo_wr_data0_o  out  Width  to FIFO first entry
- fifo_wr_data1_o  out  Width  to FIFO second entry
- fifo_wr_rdy_i  in  2  from FIFO write ready (00/01/11)
- grant_o  out  2  one-hot current grant, 00 = none
- xfer_cnt0_o  out  CntW  entries accepted from requester 0
- xfer_cnt1_o  out  CntW  entries accepted from requester 1

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- State: prio_q (1 bit, requester preferred next) and a lock FSM {IDLE, OWN0, OWN1}. Reset values: prio_q=0, FSM=IDLE, counters=0.
- Input sanitising: valid 2'b10 is treated as 00; simulation asserts fire on 10 from either requester.
- Request definition: req_k = sanitised valid_k[0].
- Grant is combinational, zero-latency:
  - OWNk: grant k regardless of req_k. The other requester is blocked even if k is idle (bubble is intended).
  - IDLE, single request: grant the requester that is requesting.
  - IDLE, both requesting: grant prio_q.
  - IDLE, neither requesting: grant none (grant_o=00, fifo_wr_valid_o=00).
- Datapath:
  - fifo_wr_valid_o and both data lanes = granted requester's; data lanes = 0 when there is no grant.
  - Granted req_rdy_o = fifo_wr_rdy_i. Ungranted req_rdy_o = 00.
- Transfer count n per cycle:
  - n=2 if valid==11 && fifo_wr_rdy_i==11.
  - else n=1 if valid[0] && fifo_wr_rdy_i[0].
  - else n=0.
  - valid=11 with rdy=01 gives n=1; the requester must re-present its second entry as entry 0 next cycle.
- prio_q update: if the granted requester k has n>0 in IDLE, prio_q <= ~k. prio_q is unchanged in OWN states and when n=0.
- Lock FSM transitions:
  - IDLE -> OWNk when k is granted, n>0 and reqk_lock_i=1.
  - OWNk -> IDLE at the end of any cycle with reqk_lock_i=0, whether or not a transfer happens that cycle.
  - On OWNk -> IDLE, prio_q <= ~k.
  - Lock asserted without a transfer does not take ownership.
- flush_i:
  - Same cycle: forces fifo_wr_valid_o=00, all req_rdy_o=00, grant_o=00.
  - Next state: IDLE, prio_q=0, counters=0.
  - flush_i has priority over all updates.
- Reset mid-burst: immediately returns to IDLE/prio 0 with outputs deasserted. Requesters must restart their bursts.
- Reset output values: with valids low, all outputs 0.

Optional Feature:
- Macro: DUAL_FIFO_ARB_CNT_EN.
- Defined: xfer_cnt0_o/xfer_cnt1_o accumulate n for their requester each cycle. Counters wrap modulo 2^CntW and are cleared by reset or flush.
- Not defined: counters are not built, and both outputs are tied to 0.

Test Plan:
- Both requesters valid=11, lock=0, fifo_rdy=11 for 4 cycles -> grant_o sequence 01,10,01,10; 8 entries written; counters 4/4 (CNT_EN).
- req0 valid=11 with lock=1 for 3 cycles, req1 valid=01 throughout -> grant 01 on all 3 cycles; req1_rdy_o=00 until cycle 4, then grant 10.
- req0 granted valid=11, fifo_rdy=01 -> req0_rdy_o=01, n=1, fifo_wr_data0_o=req0_data0_i; prio flips to 1.
- OWN0 with req0 valid=00, lock=1, req1 valid=01 -> grant stays 01, fifo_wr_valid_o=00; after lock drops, next cycle grant 10.
- flush_i during OWN1 with both valid -> same cycle fifo_wr_valid_o=00; next cycle IDLE, prio 0, grant 01, counters 0.
- Illegal req1 valid=10, req0 valid=00 -> grant_o=00, req1_rdy_o=00, assertion fires.

Source files
------------

// File: rtl/dual_fifo_wr_arb.sv
// dual_fifo_wr_arb: round-robin arbiter with burst lock for the dual-issue write port of a dual_fifo.
// Define DUAL_FIFO_ARB_CNT_EN to build the per-requester transfer counters.
module dual_fifo_wr_arb #(
  parameter int Width = 32,
  parameter int CntW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [1:0]       req0_valid_i,
  input  logic [Width-1:0] req0_data0_i,
  input  logic [Width-1:0] req0_data1_i,
  input  logic             req0_lock_i,
  output logic [1:0]       req0_rdy_o,
  input  logic [1:0]       req1_valid_i,
  input  logic [Width-1:0] req1_data0_i,
  input  logic [Width-1:0] req1_data1_i,
  input  logic             req1_lock_i,
  output logic [1:0]       req1_rdy_o,
  output logic [1:0]       fifo_wr_valid_o,
  output logic [Width-1:0] fifo_wr_data0_o,
  output logic [Width-1:0] fifo_wr_data1_o,
  input  logic [1:0]       fifo_wr_rdy_i,
  output logic [1:0]       grant_o,
  output logic [CntW-1:0]  xfer_cnt0_o,
  output logic [CntW-1:0]  xfer_cnt1_o
);
  localparam logic [1:0] IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2;
  logic [1:0] st_q, st_d;
  logic       prio_q, prio_d;
  logic [1:0] v0, v1, vg, gnt, n;
  logic       k, lock_g;
  assign v0 = (req0_valid_i == 2'b10) ? 2'b00 : req0_valid_i;
  assign v1 = (req1_valid_i == 2'b10) ? 2'b00 : req1_valid_i;
  // Outputs are also gated while reset is held so a burst in flight is cut off at once.
  assign gnt = (!rst_ni || flush_i) ? 2'b00 :
               (st_q == OWN0) ? 2'b01 :
               (st_q == OWN1) ? 2'b10 :
               (v0[0] && v1[0]) ? (prio_q ? 2'b10 : 2'b01) : {v1[0], v0[0]};
  assign k      = gnt[1];
  assign lock_g = k ? req1_lock_i : req0_lock_i;
  assign vg     = gnt[0] ? v0 : gnt[1] ? v1 : 2'b00;
  assign n      = (vg == 2'b11 && fifo_wr_rdy_i == 2'b11) ? 2'd2 :
                  (vg[0] && fifo_wr_rdy_i[0]) ? 2'd1 : 2'd0;
  assign grant_o         = gnt;
  assign fifo_wr_valid_o = vg;
  assign fifo_wr_data0_o = gnt[0] ? req0_data0_i : gnt[1] ? req1_data0_i : '0;
  assign fifo_wr_data1_o = gnt[0] ? req0_data1_i : gnt[1] ? req1_data1_i : '0;
  assign req0_rdy_o      = gnt[0] ? fifo_wr_rdy_i : 2'b00;
  assign req1_rdy_o      = gnt[1] ? fifo_wr_rdy_i : 2'b00;
  always_comb begin
    st_d   = st_q;
    prio_d = prio_q;
    if (flush_i) begin
      st_d   = IDLE;
      prio_d = 1'b0;
    end else if (st_q == OWN0 || st_q == OWN1) begin
      if (!lock_g) begin
        st_d   = IDLE;
        prio_d = ~k;
      end
    end else begin
      st_d = IDLE;
      if (n != 2'd0) begin
        prio_d = ~k;
        st_d   = lock_g ? (k ? OWN1 : OWN0) : IDLE;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= IDLE;
      prio_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      prio_q <= prio_d;
    end
  end
`ifdef DUAL_FIFO_ARB_CNT_EN
  logic [CntW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  assign cnt0_d = flush_i ? '0 : cnt0_q + (gnt[0] ? CntW'(n) : '0);
  assign cnt1_d = flush_i ? '0 : cnt1_q + (gnt[1] ? CntW'(n) : '0);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign xfer_cnt0_o = cnt0_q;
  assign xfer_cnt1_o = cnt1_q;
`else
  assign xfer_cnt0_o = '0;
  assign xfer_cnt1_o = '0;
`endif
`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (req0_valid_i != 2'b10) else $warning("req0_valid_i=10 is illegal, treated as 00");
      assert (req1_valid_i != 2'b10) else $warning("req1_valid_i=10 is illegal, treated as 00");
    end
  end
`endif
endmodule

// File: tb/tb_dual_fifo_wr_arb.sv
// tb_dual_fifo_wr_arb: directed vectors with hand-computed expectations for dual_fifo_wr_arb.
module tb_dual_fifo_wr_arb;
`ifdef DUAL_FIFO_ARB_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA111_1111;
  localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB111_1111;
  logic        clk = 1'b0, rst_ni, flush_i;
  logic [1:0]  req0_valid_i, req1_valid_i, req0_rdy_o, req1_rdy_o;
  logic [31:0] req0_data0_i, req0_data1_i, req1_data0_i, req1_data1_i;
  logic        req0_lock_i, req1_lock_i;
  logic [1:0]  fifo_wr_valid_o, fifo_wr_rdy_i, grant_o;
  logic [31:0] fifo_wr_data0_o, fifo_wr_data1_o;
  logic [15:0] xfer_cnt0_o, xfer_cnt1_o;
  int vectors = 0, errors = 0, ent = 0;
  dual_fifo_wr_arb dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_data0_i(req0_data0_i), .req0_data1_i(req0_data1_i),
    .req0_lock_i(req0_lock_i), .req0_rdy_o(req0_rdy_o),
    .req1_valid_i(req1_valid_i), .req1_data0_i(req1_data0_i), .req1_data1_i(req1_data1_i),
    .req1_lock_i(req1_lock_i), .req1_rdy_o(req1_rdy_o),
    .fifo_wr_valid_o(fifo_wr_valid_o), .fifo_wr_data0_o(fifo_wr_data0_o),
    .fifo_wr_data1_o(fifo_wr_data1_o), .fifo_wr_rdy_i(fifo_wr_rdy_i),
    .grant_o(grant_o), .xfer_cnt0_o(xfer_cnt0_o), .xfer_cnt1_o(xfer_cnt1_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v0, input logic l0, input logic [1:0] v1,
                       input logic l1, input logic [1:0] rdy, input logic fl);
    req0_valid_i = v0; req0_lock_i = l0;
    req1_valid_i = v1; req1_lock_i = l1;
    fifo_wr_rdy_i = rdy; flush_i = fl;
    #3;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    req0_data0_i = A0; req0_data1_i = A1; req1_data0_i = B0; req1_data1_i = B1;
    rst_ni = 1'b0;
    drive(2'b00, 0, 2'b00, 0, 2'b11, 0);
    check("rst_grant", grant_o, 2'b00);
    check("rst_fvalid", fifo_wr_valid_o, 2'b00);
    check("rst_d0", fifo_wr_data0_o, 0);
    check("rst_rdy", {req0_rdy_o, req1_rdy_o}, 4'b0000);
    check("rst_cnt", {xfer_cnt0_o, xfer_cnt1_o}, 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    // round-robin alternation, both requesters streaming pairs
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 0, 2'b11, 0, 2'b11, 0);
      check("rr_grant", grant_o, (i % 2) ? 2'b10 : 2'b01);
      check("rr_d1", fifo_wr_data1_o, (i % 2) ? B1 : A1);
      ent += fifo_wr_valid_o[0] + fifo_wr_valid_o[1];
      step();
    end
    check("rr_entries", ent, 8);
    check("rr_cnt0", xfer_cnt0_o, CE ? 4 : 0);
    check("rr_cnt1", xfer_cnt1_o, CE ? 4 : 0);
    // req0 locked burst; req1 blocked until the lock is released
    drive(2'b11, 1, 2'b01, 0, 2'b11, 0);
    check("lk_g1", grant_o, 2'b01);
    check("lk_r1rdy1", req1_rdy_o, 2'b00);
    step();
    drive(2'b11, 1, 2'b01, 0, 2'b11, 0);
    check("lk_g2", grant_o, 2'b01);
    step();
    drive(2'b11, 0, 2'b01, 0, 2'b11, 0);
    check("lk_g3", grant_o, 2'b01);
    check("lk_r1rdy3", req1_rdy_o, 2'b00);
    step();
    drive(2'b00, 0, 2'b01, 0, 2'b11, 0);
    check("lk_g4", grant_o, 2'b10);
    check("lk_r1rdy4", req1_rdy_o, 2'b11);
    check("lk_d0", fifo_wr_data0_o, B0);
    step();
    check("lk_cnt0", xfer_cnt0_o, CE ? 10 : 0);
    check("lk_cnt1", xfer_cnt1_o, CE ? 5 : 0);
    // partial acceptance: pair offered, only one slot free
    drive(2'b11, 0, 2'b00, 0, 2'b01, 0);
    check("pa_grant", grant_o, 2'b01);
    check("pa_r0rdy", req0_rdy_o, 2'b01);
    check("pa_d0", fifo_wr_data0_o, A0);
    step();
    check("pa_cnt0", xfer_cnt0_o, CE ? 11 : 0);
    drive(2'b01, 0, 2'b01, 0, 2'b11, 0);
    check("pa_prio", grant_o, 2'b10);
    step();
    // idle owner keeps the port: bubble for the other requester
    drive(2'b01, 1, 2'b00, 0, 2'b11, 0);
    check("bb_g0", grant_o, 2'b01);
    step();
    drive(2'b00, 1, 2'b01, 0, 2'b11, 0);
    check("bb_g1", grant_o, 2'b01);
    check("bb_fv1", fifo_wr_valid_o, 2'b00);
    check("bb_r1rdy", req1_rdy_o, 2'b00);
    step();
    drive(2'b00, 0, 2'b01, 0, 2'b11, 0);
    check("bb_g2", grant_o, 2'b01);
    check("bb_fv2", fifo_wr_valid_o, 2'b00);
    step();
    drive(2'b00, 0, 2'b01, 0, 2'b11, 0);
    check("bb_g3", grant_o, 2'b10);
    check("bb_fv3", fifo_wr_valid_o, 2'b01);
    step();
    // flush while req1 owns the port
    drive(2'b00, 0, 2'b11, 1, 2'b11, 0);
    check("fl_own", grant_o, 2'b10);
    step();
    drive(2'b11, 0, 2'b11, 1, 2'b11, 1);
    check("fl_grant", grant_o, 2'b00);
    check("fl_fvalid", fifo_wr_valid_o, 2'b00);
    check("fl_rdy", {req0_rdy_o, req1_rdy_o}, 4'b0000);
    check("fl_cnt1_pre", xfer_cnt1_o, CE ? 9 : 0);
    step();
    drive(2'b11, 0, 2'b11, 0, 2'b11, 0);
    check("fl_after", grant_o, 2'b01);
    check("fl_cnt", {xfer_cnt0_o, xfer_cnt1_o}, 0);
    step();
    // illegal 10 pattern is treated as no request
    drive(2'b00, 0, 2'b10, 0, 2'b11, 0);
    check("il_grant", grant_o, 2'b00);
    check("il_r1rdy", req1_rdy_o, 2'b00);
    check("il_fvalid", fifo_wr_valid_o, 2'b00);
    step();
    // reset in the middle of a locked burst
    drive(2'b11, 1, 2'b00, 0, 2'b11, 0);
    check("mr_own", grant_o, 2'b01);
    step();
    drive(2'b11, 1, 2'b01, 0, 2'b11, 0);
    rst_ni = 1'b0;
    #1;
    check("mr_grant", grant_o, 2'b00);
    check("mr_fvalid", fifo_wr_valid_o, 2'b00);
    check("mr_cnt0", xfer_cnt0_o, 0);
    step();
    rst_ni = 1'b1;
    drive(2'b00, 0, 2'b01, 0, 2'b11, 0);
    check("mr_idle", grant_o, 2'b10);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
